// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions used by the multiply/divide unit.
//   funct_t / FUNCT_*  : R-type function codes that start an HI/LO operation
//   mdu_state_t        : sequencer states of the multiply/divide unit
//   mdu_op_t           : decoded operation flags handed to the datapath
package mult_div_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DWIDTH = 2 * XLEN;
    localparam int unsigned CNT_W = 6;

    typedef logic [5:0] funct_t;

    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_ITER = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_t;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } mdu_op_t;

    // True for the four function codes that launch an operation.
    function automatic logic is_mdu_op(funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic mdu_op_t decode_op(funct_t f);
        mdu_op_t op;
        op.is_div    = (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
        op.is_signed = (f == FUNCT_MULT) || (f == FUNCT_DIV);
        return op;
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Arithmetic datapath of the multiply/divide unit: operand magnitudes,
// 64-bit accumulator, one-bit-per-cycle shift-add / restoring-divide step,
// and the sign / divide-by-zero fixup that produces the HI/LO result.
// Optional feature macro: MDU_FAST_MULT_EN (product formed at load time).
//   clk, reset_n      : clock, async active-low reset
//   load              : latch operands and clear accumulator
//   iter_en           : perform one iteration step
//   op_in             : decoded operation, sampled on load
//   a, b              : rs / rt operands, sampled on load
//   res_hi_c/res_lo_c : fixed-up result (combinational from registers)
module mdu_datapath
    import mult_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            iter_en,
    input  mdu_op_t         op_in,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_hi_c,
    output logic [XLEN-1:0] res_lo_c
);

    logic [DWIDTH-1:0] acc_q,     acc_d;
    logic [XLEN-1:0]   opnd_q,    opnd_d;    // multiplier / dividend, consumed bitwise
    logic [XLEN-1:0]   dsor_q,    dsor_d;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]   a_raw_q,   a_raw_d;   // unmodified dividend for divide-by-zero
    logic              is_div_q,  is_div_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dbz_q,     dbz_d;

    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     trial, diff, sum;
    logic [DWIDTH-1:0] prod;

    // Next-state of operand/accumulator registers.
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        dsor_d    = dsor_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        mag_a = (op_in.is_signed && a[XLEN-1]) ? -a : a;
        mag_b = (op_in.is_signed && b[XLEN-1]) ? -b : b;

        // Divide step: shift in next dividend bit, trial-subtract divisor.
        trial = {acc_q[DWIDTH-1:XLEN], opnd_q[XLEN-1]};
        diff  = trial - {1'b0, dsor_q};
        // Multiply step: conditional add into upper half, with carry.
        sum   = {1'b0, acc_q[DWIDTH-1:XLEN]} + (opnd_q[0] ? {1'b0, dsor_q} : '0);

        if (load) begin
            opnd_d    = mag_a;
            dsor_d    = mag_b;
            a_raw_d   = a;
            is_div_d  = op_in.is_div;
            neg_quo_d = op_in.is_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_d = op_in.is_signed && a[XLEN-1];
            dbz_d     = (b == '0);
            acc_d     = '0;
`ifdef MDU_FAST_MULT_EN
            if (!op_in.is_div) begin
                acc_d = DWIDTH'(mag_a) * DWIDTH'(mag_b);
            end
`endif
        end else if (iter_en) begin
            if (is_div_q) begin
                // diff[XLEN] set means borrow: keep the shifted remainder.
                if (!diff[XLEN]) begin
                    acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                opnd_d = {opnd_q[XLEN-2:0], 1'b0};
            end else begin
                acc_d  = {sum, acc_q[XLEN-1:1]};
                opnd_d = {1'b0, opnd_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            dsor_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            dsor_q    <= dsor_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    // Sign fixup; divide-by-zero bypasses it and returns the raw dividend.
    always_comb begin
        prod     = neg_quo_q ? -acc_q : acc_q;
        res_hi_c = prod[DWIDTH-1:XLEN];
        res_lo_c = prod[XLEN-1:0];
        if (is_div_q) begin
            if (dbz_q) begin
                res_hi_c = a_raw_q;
                res_lo_c = '1;
            end else begin
                res_lo_c = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                res_hi_c = neg_rem_q ? -acc_q[DWIDTH-1:XLEN] : acc_q[DWIDTH-1:XLEN];
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Holds the sequencer, iteration counter and HI/LO; arithmetic lives in
// mdu_datapath. Optional feature macro: MDU_FAST_MULT_EN (multiply skips
// the iteration phase and finishes two cycles after acceptance).
//   clk, reset_n : clock, async active-low reset
//   start        : request strobe, honoured only while idle
//   fncode       : function code selecting the operation
//   a, b         : rs / rt operands
//   mthi, mtlo   : write wdata into HI / LO while idle
//   wdata        : MTHI/MTLO data
//   busy         : operation in flight
//   done         : one-cycle pulse, HI/LO just updated
//   hi, lo       : architectural HI / LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  funct_t          fncode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned ITER_LAST = XLEN - 1;

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [XLEN-1:0]  hi_q,    hi_d;
    logic [XLEN-1:0]  lo_q,    lo_d;

    logic            accept_c;
    logic            load_c;
    logic            iter_en_c;
    mdu_op_t         op_c;
    logic [XLEN-1:0] res_hi_c, res_lo_c;

    assign op_c     = decode_op(fncode);
    assign accept_c = start && (state_q == MDU_IDLE) && is_mdu_op(fncode);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept_c) begin
`ifdef MDU_FAST_MULT_EN
                    state_d = op_c.is_div ? MDU_ITER : MDU_FIX;
`else
                    state_d = MDU_ITER;
`endif
                end
            end
            MDU_ITER: begin
                if (cnt_q == CNT_W'(ITER_LAST)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX:  state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Output / datapath-control logic.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        load_c    = 1'b0;
        iter_en_c = 1'b0;
        busy_d    = (state_d != MDU_IDLE);
        done_d    = (state_q == MDU_FIX);
        case (state_q)
            MDU_IDLE: begin
                // A same-cycle start still takes the move; the result overwrites later.
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (accept_c) begin
                    load_c = 1'b1;
                    cnt_d  = '0;
                end
            end
            MDU_ITER: begin
                iter_en_c = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
            end
            MDU_FIX: begin
                hi_d  = res_hi_c;
                lo_d  = res_lo_c;
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    mdu_datapath u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_c),
        .iter_en  (iter_en_c),
        .op_in    (op_c),
        .a        (a),
        .b        (b),
        .res_hi_c (res_hi_c),
        .res_lo_c (res_lo_c)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, move/start
// interference, mid-operation reset and randomized operations compared
// against an arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    funct_t      fncode;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .fncode  (fncode),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input funct_t f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (f)
            FUNCT_MULT:  return 64'(sx * sy);
            FUNCT_MULTU: return 64'(ux * uy);
            FUNCT_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    function automatic int exp_lat(input funct_t f);
`ifdef MDU_FAST_MULT_EN
        if (f == FUNCT_MULT || f == FUNCT_MULTU) return 2;
`endif
        return 34;
    endfunction

    // Drive a request and return just after the accepting edge.
    task automatic issue(input funct_t f, input logic [31:0] x, input logic [31:0] y);
        start  = 1'b1;
        fncode = f;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done (bounded) and check latency, result and single pulse.
    task automatic finish(input string tag, input funct_t f, input logic [31:0] x,
                          input logic [31:0] y, input int pre);
        int n;
        logic [63:0] e;
        n = pre;
        e = model(f, x, y);
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat(f)));
        chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input funct_t f, input logic [31:0] x, input logic [31:0] y);
        issue(f, x, y);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        finish(tag, f, x, y, 1);
    endtask

    initial begin
        logic [31:0] x, y, hold_hi;
        funct_t      f;
        int          pulses;
        int          sel;

        reset_n = 1'b0;
        start   = 1'b0;
        fncode  = '0;
        a       = '0;
        b       = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        wdata   = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op("mult_neg3x5", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5);
        @(negedge clk);
        chk("mult_done_once", 64'(done), 64'd0);
        run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
        run_op("divu_by0", FUNCT_DIVU, 32'd5, 32'd0);
        run_op("div_by0_neg", FUNCT_DIV, 32'hFFFF_FFF7, 32'd0);
        run_op("div_minint", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_minint", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000);

        // Non-MDU function code with start: ignored.
        fncode = 6'h20;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_fn_busy", 64'(busy), 64'd0);

        // start + mthi while busy are both ignored.
        issue(FUNCT_DIVU, 32'd1000, 32'd9);
        repeat (9) @(negedge clk);
        start  = 1'b1;
        fncode = FUNCT_MULT;
        a      = 32'd3;
        b      = 32'd3;
        mthi   = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        chk("intf_busy", 64'(busy), 64'd1);
        finish("intf", FUNCT_DIVU, 32'd1000, 32'd9, 10);

        // Reset mid-operation discards it.
        issue(FUNCT_DIVU, 32'd12345, 32'd11);
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);

        // Moves while idle.
        mtlo  = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h1234);
        chk("mtlo_hi", 64'(hi), 64'd0);
        mthi  = 1'b1;
        wdata = 32'h5678;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h5678);
        hold_hi = hi;
        chk("mthi_lo_kept", 64'(lo), 64'h1234);

        // Move and start in the same cycle: result overwrites the move.
        mthi  = 1'b1;
        wdata = 32'hCAFE_F00D;
        issue(FUNCT_MULTU, 32'h0001_0000, 32'h0003_0000);
        mthi = 1'b0;
        @(negedge clk);
        chk("mt_start_hi_written", 64'(hi), 64'hCAFE_F00D);
        finish("mt_start", FUNCT_MULTU, 32'h0001_0000, 32'h0003_0000, 1);
        chk("mt_start_hi_changed", 64'(hi !== hold_hi), 64'd1);

        // Randomized back-to-back operations.
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 3);
            f   = (sel == 0) ? FUNCT_MULT : (sel == 1) ? FUNCT_MULTU :
                  (sel == 2) ? FUNCT_DIV  : FUNCT_DIVU;
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            if (sel == 1) x = 32'h8000_0000;
            if (sel == 2) y = 32'hFFFF_FFFF;
            if (sel == 3) y = 32'(y[7:0]);
            issue(f, x, y);
            finish($sformatf("rand%0d", i), f, x, y, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
